// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides and a registered result and flags.
// Define ALU_MC_DIV_EN to build the restoring divider; without it DIV is reported as illegal.
module alu_mc #(
  parameter int WIDTH_DATA = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op_code,
  input  logic [WIDTH_DATA-1:0] operand_a,
  input  logic [WIDTH_DATA-1:0] operand_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_DATA-1:0] result,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  flag_dbz,
  output logic                  flag_illegal
);

  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_MUL  = 5'd6;
  localparam logic [4:0] OP_DIV  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_NAND = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_XOR  = 5'd11;
  localparam logic [4:0] OP_CMP  = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  typedef struct packed {
    logic [WIDTH_DATA-1:0] value;
    logic                  zero;
    logic                  carry;
    logic                  dbz;
    logic                  illegal;
  } res_t;

  state_t state_q, state_d, acc_state;
  res_t   op_res, res_q;
  logic   accept;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  assign result       = res_q.value;
  assign flag_zero    = res_q.zero;
  assign flag_carry   = res_q.carry;
  assign flag_dbz     = res_q.dbz;
  assign flag_illegal = res_q.illegal;

`ifdef ALU_MC_DIV_EN
  localparam int CNT_W = $clog2(WIDTH_DATA);

  logic                  go_div;
  logic [WIDTH_DATA-1:0] rem_q, quo_q, dvs_q, rem_d, quo_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [WIDTH_DATA:0]   rem_sh, diff;
  logic                  div_last;

  // One restoring step: a borrow out of the trial subtraction means the quotient bit is 0.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH_DATA-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    rem_d    = diff[WIDTH_DATA] ? rem_sh[WIDTH_DATA-1:0] : diff[WIDTH_DATA-1:0];
    quo_d    = {quo_q[WIDTH_DATA-2:0], ~diff[WIDTH_DATA]};
    div_last = (cnt_q == CNT_W'(WIDTH_DATA - 1));
  end
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    op_res = '0;
`ifdef ALU_MC_DIV_EN
    go_div = 1'b0;
`endif
    case (op_code)
      OP_ADD:  {op_res.carry, op_res.value} = {1'b0, operand_a} + {1'b0, operand_b};
      OP_SUB: begin
        op_res.value = operand_a - operand_b;
        op_res.carry = (operand_a < operand_b);
      end
      OP_MUL:  op_res.value = operand_a * operand_b;
`ifdef ALU_MC_DIV_EN
      OP_DIV: begin
        if (operand_b == '0) op_res.dbz = 1'b1;
        else                 go_div     = 1'b1;
      end
`endif
      OP_AND:  op_res.value = operand_a & operand_b;
      OP_NAND: op_res.value = ~(operand_a & operand_b);
      OP_OR:   op_res.value = operand_a | operand_b;
      OP_XOR:  op_res.value = operand_a ^ operand_b;
      OP_CMP: begin
        if (operand_a == operand_b)     op_res.value = '0;
        else if (operand_a > operand_b) op_res.value = WIDTH_DATA'(1);
        else                            op_res.value = '1;
      end
      OP_NOT:  op_res.value = ~operand_a;
      default: op_res.illegal = 1'b1;
    endcase
    op_res.zero = (op_res.value == '0);
  end

  always_comb begin
`ifdef ALU_MC_DIV_EN
    acc_state = go_div ? DIV_RUN : DONE;
`else
    acc_state = DONE;
`endif
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = acc_state;
`ifdef ALU_MC_DIV_EN
      DIV_RUN: if (div_last) state_d = DONE;
`endif
      DONE:    if (out_ready) state_d = accept ? acc_state : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Result registers only load on an accepted single-cycle op or the final divide step,
  // which keeps them stable while a result waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
`ifdef ALU_MC_DIV_EN
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
`ifdef ALU_MC_DIV_EN
      if (accept && go_div) begin
        rem_q <= '0;
        quo_q <= operand_a;
        dvs_q <= operand_b;
        cnt_q <= '0;
      end else if (state_q == DIV_RUN) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 1'b1;
        if (div_last)
          res_q <= '{value: quo_d, zero: (quo_d == '0), carry: 1'b0, dbz: 1'b0, illegal: 1'b0};
      end
      if (accept && !go_div) res_q <= op_res;
`else
      if (accept) res_q <= op_res;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH_DATA=16; DIV expectations follow whether ALU_MC_DIV_EN is defined.
module tb_alu_mc;

  localparam int W = 16;
  localparam logic [4:0] OP_ADD = 5'd4,  OP_SUB = 5'd5,  OP_MUL = 5'd6,  OP_DIV = 5'd7;
  localparam logic [4:0] OP_AND = 5'd8,  OP_NAND = 5'd9, OP_OR = 5'd10,  OP_XOR = 5'd11;
  localparam logic [4:0] OP_CMP = 5'd12, OP_NOT = 5'd13;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]   op_code = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, flag_zero, flag_carry, flag_dbz, flag_illegal;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH_DATA(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_code(op_code),
    .operand_a(a), .operand_b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_dbz(flag_dbz), .flag_illegal(flag_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b, res;
    logic [3:0]  f;  // {zero, carry, dbz, illegal}
  } vec_t;

  function automatic vec_t mk(logic [4:0] op, logic [15:0] x, y, r, logic [3:0] f);
    vec_t v;
    v.op = op; v.a = x; v.b = y; v.res = r; v.f = f;
    return v;
  endfunction

  function automatic logic [21:0] obs();
    return {in_ready, out_valid, result, flag_zero, flag_carry, flag_dbz, flag_illegal};
  endfunction

  function automatic logic [21:0] ex(logic ir, logic ov, logic [15:0] r, logic [3:0] f);
    return {ir, ov, r, f};
  endfunction

  function automatic string fmt(logic [21:0] v);
    return $sformatf("in_ready=%b out_valid=%b result=%h zcdi=%b", v[21], v[20], v[19:4], v[3:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [4:0] op, logic [15:0] x, y);
    in_valid = 1'b1; op_code = op; a = x; b = y;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    e = ex(1, 0, 16'h0000, 4'b0000);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_hold: got %s want %s", fmt(obs()), fmt(e)); end
    @(negedge clk) rst_n = 1'b1;
    step();
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_release: got %s want %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_add_carry();
    logic [21:0] e;
    out_ready = 1'b1;
    drive(OP_ADD, 16'hFFFF, 16'h0001);
    step();
    in_valid = 1'b0;
    e = ex(1, 1, 16'h0000, 4'b1100);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL add_carry: got %s want %s", fmt(obs()), fmt(e)); end
    step();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL add_carry_retire: got ir/ov=%b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_ops();
    vec_t v[$];
    logic [21:0] e;
    v.push_back(mk(OP_ADD,  16'h1234, 16'h1111, 16'h2345, 4'b0000));
    v.push_back(mk(OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 4'b0100));
    v.push_back(mk(OP_SUB,  16'h0007, 16'h0007, 16'h0000, 4'b1000));
    v.push_back(mk(OP_MUL,  16'h0123, 16'h0100, 16'h2300, 4'b0000));
    v.push_back(mk(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000));
    v.push_back(mk(OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000));
    v.push_back(mk(OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000));
    v.push_back(mk(OP_NAND, 16'h00FF, 16'h0F0F, 16'hFFF0, 4'b0000));
    v.push_back(mk(OP_OR,   16'hF000, 16'h000F, 16'hF00F, 4'b0000));
    v.push_back(mk(OP_XOR,  16'hA5A5, 16'hFFFF, 16'h5A5A, 4'b0000));
    v.push_back(mk(OP_NOT,  16'h1234, 16'hFFFF, 16'hEDCB, 4'b0000));
    v.push_back(mk(5'd0,    16'h1111, 16'h2222, 16'h0000, 4'b1001));
    v.push_back(mk(5'd14,   16'h1111, 16'h2222, 16'h0000, 4'b1001));
    v.push_back(mk(5'd31,   16'hFFFF, 16'hFFFF, 16'h0000, 4'b1001));
`ifdef ALU_MC_DIV_EN
    v.push_back(mk(OP_DIV,  16'h0005, 16'h0000, 16'h0000, 4'b1010));
`else
    v.push_back(mk(OP_DIV,  16'h0005, 16'h0000, 16'h0000, 4'b1001));
    v.push_back(mk(OP_DIV,  16'd100,  16'd7,    16'h0000, 4'b1001));
`endif
    out_ready = 1'b1;
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      step();
      in_valid = 1'b0;
      e = ex(1, 1, v[i].res, v[i].f);
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL op%0d_vec%0d: got %s want %s", v[i].op, i, fmt(obs()), fmt(e));
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL op_retire_vec%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e;
    out_ready = 1'b1;
    drive(OP_CMP, 16'd3, 16'd9);
    step();
    e = ex(1, 1, 16'hFFFF, 4'b0000);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL cmp_lt: got %s want %s", fmt(obs()), fmt(e)); end
    drive(OP_CMP, 16'd9, 16'd3);
    step();
    e = ex(1, 1, 16'h0001, 4'b0000);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL cmp_gt: got %s want %s", fmt(obs()), fmt(e)); end
    drive(OP_CMP, 16'd9, 16'd9);
    step();
    in_valid = 1'b0;
    e = ex(1, 1, 16'h0000, 4'b1000);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL cmp_eq: got %s want %s", fmt(obs()), fmt(e)); end
    step();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL cmp_retire: got ir/ov=%b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_hold();
    logic [21:0] e;
    out_ready = 1'b0;
    drive(OP_XOR, 16'h00F0, 16'h0FF0);
    step();
    drive(OP_ADD, 16'h0001, 16'h0001);  // must be ignored while the result is held
    e = ex(0, 1, 16'h0F00, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL hold_c%0d: got %s want %s", i, fmt(obs()), fmt(e)); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    e = ex(1, 1, 16'h0F00, 4'b0000);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL hold_release: got %s want %s", fmt(obs()), fmt(e)); end
    step();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL hold_retire: got ir/ov=%b want 10", {in_ready, out_valid});
    end
  endtask

`ifdef ALU_MC_DIV_EN
  task automatic test_div();
    vec_t v[$];
    logic [21:0] e;
    int n;
    v.push_back(mk(OP_DIV, 16'd100,   16'd7,    16'd14,   4'b0000));
    v.push_back(mk(OP_DIV, 16'd7,     16'd9,    16'd0,    4'b1000));
    v.push_back(mk(OP_DIV, 16'hFFFF,  16'h0010, 16'h0FFF, 4'b0000));
    foreach (v[i]) begin
      out_ready = 1'b0;
      drive(v[i].op, v[i].a, v[i].b);
      step();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 40) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL div%0d_busy_c%0d: got in_ready=%b want 0", i, n, in_ready);
        end
        step();
        n++;
      end
      n_checks++;
      if (n !== 17) begin n_fail++; $display("FAIL div%0d_latency: got %0d cycles want 17", i, n); end
      e = ex(0, 1, v[i].res, v[i].f);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL div%0d_result: got %s want %s", i, fmt(obs()), fmt(e)); end
      out_ready = 1'b1;
      step();
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [21:0] e;
    int seen;
`ifdef ALU_MC_DIV_EN
    out_ready = 1'b1;
    drive(OP_DIV, 16'd100, 16'd7);
    step();
    in_valid = 1'b0;
    repeat (7) step();
`else
    out_ready = 1'b0;
    drive(OP_XOR, 16'h00F0, 16'h0FF0);
    step();
    in_valid = 1'b0;
    step();
`endif
    rst_n = 1'b0;
    #1;
    e = ex(1, 0, 16'h0000, 4'b0000);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_mid: got %s want %s", fmt(obs()), fmt(e)); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    drive(5'd3, 16'h1234, 16'h5678);
    step();
    in_valid = 1'b0;
    e = ex(1, 1, 16'h0000, 4'b1001);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_illegal: got %s want %s", fmt(obs()), fmt(e)); end
    seen = 0;
    repeat (20) begin
      step();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_stale: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_ops();
    test_back_to_back();
    test_hold();
`ifdef ALU_MC_DIV_EN
    test_div();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH_DATA, default 16, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port: op_code  input  5  operation: ADD=4, SUB=5, MUL=6, DIV=7, AND=8, NAND=9, OR=10, XOR=11, CMP=12, NOT=13.
REQ-007 SHALL have port: operand_a, operand_b  input  WIDTH_DATA  unsigned operands.
REQ-008 SHALL have port: out_valid  output  1  result/flags valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: result  output  WIDTH_DATA  registered result.
REQ-011 SHALL have port: flag_zero, flag_carry, flag_dbz, flag_illegal  output  1 each  registered status.

Function
REQ-012 SHALL implement FSM states IDLE, DIV_RUN, DONE.
REQ-013 SHALL accept a request when in_valid && in_ready; op_code and operands captured that edge.
REQ-014 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back issue gives one result per cycle for non-DIV ops.
REQ-015 SHALL, for non-DIV ops, go to DONE with out_valid=1 the cycle after acceptance (latency 1).
REQ-016 SHALL, for DIV with operand_b!=0, enter DIV_RUN, run a restoring divider at 1 quotient bit per cycle for WIDTH_DATA cycles, then DONE (latency WIDTH_DATA+1).
REQ-017 SHALL, for DIV with operand_b==0, go directly to DONE after 1 cycle: result=0, flag_dbz=1.
REQ-018 SHALL hold result and flags stable while out_valid && !out_ready.
REQ-019 SHALL leave DONE on out_valid && out_ready: to IDLE if no new accept, else to the accepted op's next state.
REQ-020 SHALL compute ADD/SUB modulo 2^WIDTH_DATA; flag_carry = carry-out for ADD, borrow (a<b) for SUB, 0 otherwise.
REQ-021 SHALL return the low WIDTH_DATA bits of the product for MUL.
REQ-022 SHALL return bitwise AND, ~(a&b), OR, XOR, ~a for codes 8, 9, 10, 11, 13.
REQ-023 SHALL return for CMP: 0 if a==b, 1 if a>b, all-ones if a<b (unsigned compare).
REQ-024 SHALL, for any other op_code, return result=0 with flag_illegal=1 at latency 1.
REQ-025 SHALL set flag_zero = (result==0) for every completed op; flags not named for an op SHALL be 0.
REQ-026 SHALL ignore in_valid while in DIV_RUN or DONE without out_ready (in_ready=0).

Reset
REQ-027 SHALL, on rst_n low, asynchronously force state=IDLE, out_valid=0, result=0, all flags=0, divider registers=0; in_ready=1 after release.
REQ-028 SHALL abandon an in-flight DIV or undelivered result on reset mid-operation; no output produced for it.

Configuration
REQ-029 SHALL support macro ALU_MC_DIV_EN: defined -> DIV per REQ-016/017; undefined -> divider logic and DIV_RUN absent, DIV treated as illegal per REQ-024.

Verification
REQ-030 SHALL cover: ADD a=0xFFFF b=0x0001 -> 1 cycle later out_valid=1, result=0x0000, flag_zero=1, flag_carry=1.
REQ-031 SHALL cover: DIV a=100 b=7 (DIV_EN) -> out_valid exactly 17 cycles after accept, result=14, flag_dbz=0; in_ready=0 throughout.
REQ-032 SHALL cover: DIV a=5 b=0 -> 1 cycle later result=0, flag_dbz=1, flag_zero=1.
REQ-033 SHALL cover: CMP (3,9), (9,3), (9,9) issued back-to-back with out_ready=1 -> results 0xFFFF, 0x0001, 0x0000 on three consecutive cycles.
REQ-034 SHALL cover: XOR 0x00F0^0x0FF0 with out_ready=0 for 5 cycles -> result 0x0F00 held stable, in_ready=0, then released on out_ready=1.
REQ-035 SHALL cover: rst_n pulsed low during DIV_RUN cycle 8 -> out_valid=0, result=0, in_ready=1 immediately; op_code=3 afterwards -> flag_illegal=1.
